fifo_stim_driver: RTL and testbench

//  Synthesizable stimulus source for the FIFO environment. It drives the FIFO write and read

---
 rtl/fifo_stim_driver_if.sv | 21 ++
 rtl/fifo_stim_driver.sv | 183 ++++++++++++++++++
 tb/tb_fifo_stim_driver.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_stim_driver_if.sv
// Stimulus bundle between fifo_stim_driver and the FIFO DUT / monitor.
// master = stimulus driver, slave = consumers (DUT inputs, monitor trigger/finish).
interface fifo_stim_driver_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  fifo_rst_n;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  sample_strobe;
    logic                  test_done;
    logic [31:0]           txn_count;

    modport master (
        output fifo_rst_n, wr_en, rd_en, data_in, sample_strobe, test_done, txn_count
    );

    modport slave (
        input fifo_rst_n, wr_en, rd_en, data_in, sample_strobe, test_done, txn_count
    );
endinterface

// File: rtl/fifo_stim_driver.sv
// FIFO stimulus source: RST -> FILL -> DRAIN -> RANDOM -> DONE with strobe/finish handshake.
// Optional FIFO_DRV_RST_INJECT_EN: mid-RANDOM FIFO reset injection.
module fifo_stim_driver #(
    parameter int          DATA_WIDTH = 16,
    parameter int          DEPTH      = 8,
    parameter int          NUM_TXN    = 1000,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          WR_THRESH  = 179,
    parameter int          RD_THRESH  = 77
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    fifo_stim_driver_if.master    drv
);
    localparam int          PH       = DEPTH + 2;
    localparam int          MAXC     = (PH > NUM_TXN) ? PH : NUM_TXN;
    localparam int          CW       = $clog2(MAXC + 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [CW-1:0] PH_LAST  = CW'(PH - 1);
    localparam logic [CW-1:0] RND_LAST = CW'(NUM_TXN - 1);
    localparam logic [CW-1:0] INJ_IDX  = CW'(NUM_TXN / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FILL,
        S_DRAIN,
        S_RANDOM,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [15:0]           lfsr, lfsr_nxt, lfsr_step;
    logic                  frst_q, frst_nxt;
    logic                  wr_q, wr_nxt;
    logic                  rd_q, rd_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic                  strobe_q, strobe_nxt;
    logic                  done_q, done_nxt;
    logic [31:0]           txn_q, txn_nxt;
    logic                  stim_cur, stim_nxt;

    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign stim_cur  = (state == S_FILL) || (state == S_DRAIN) || (state == S_RANDOM);
    assign stim_nxt  = (state_nxt == S_FILL) || (state_nxt == S_DRAIN) || (state_nxt == S_RANDOM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts cycles spent in the current phase; in DONE it saturates at 1
    // so that cnt==0 marks the first DONE cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start) state_nxt = S_RST;
            end
            S_RST: begin
                if (cnt == CW'(1)) begin
                    state_nxt = S_FILL;
                    cnt_nxt   = '0;
                end
            end
            S_FILL: begin
                if (cnt == PH_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == PH_LAST) begin
                    state_nxt = S_RANDOM;
                    cnt_nxt   = '0;
                end
            end
            S_RANDOM: begin
                if (cnt == RND_LAST) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                cnt_nxt = CW'(1);
                if (start) begin
                    state_nxt = S_RST;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so the output registers
    // always describe the cycle the FSM is in.
    always_comb begin
        frst_nxt   = 1'b1;
        wr_nxt     = 1'b0;
        rd_nxt     = 1'b0;
        data_nxt   = data_q;
        txn_nxt    = txn_q;
        lfsr_nxt   = lfsr;
        strobe_nxt = stim_cur;
        done_nxt   = 1'b0;
        unique case (state_nxt)
            S_RST: begin
                frst_nxt = 1'b0;
                txn_nxt  = '0;
            end
            S_FILL:  wr_nxt = 1'b1;
            S_DRAIN: rd_nxt = 1'b1;
            S_RANDOM: begin
                wr_nxt = (int'(lfsr[7:0])  < WR_THRESH);
                rd_nxt = (int'(lfsr[15:8]) < RD_THRESH);
`ifdef FIFO_DRV_RST_INJECT_EN
                if (cnt_nxt == INJ_IDX) begin
                    frst_nxt = 1'b0;
                    wr_nxt   = 1'b0;
                    rd_nxt   = 1'b0;
                end
`endif
            end
            S_DONE: begin
                if (state == S_DONE) begin
                    done_nxt = (cnt == '0) ? 1'b1 : done_q;
                    if (cnt == '0) strobe_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        if (stim_nxt) begin
            data_nxt = lfsr[DATA_WIDTH-1:0];
            txn_nxt  = txn_q + 32'd1;
            lfsr_nxt = lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frst_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            txn_q    <= '0;
            lfsr     <= SEED_EFF;
        end else begin
            frst_q   <= frst_nxt;
            wr_q     <= wr_nxt;
            rd_q     <= rd_nxt;
            data_q   <= data_nxt;
            strobe_q <= strobe_nxt;
            done_q   <= done_nxt;
            txn_q    <= txn_nxt;
            lfsr     <= lfsr_nxt;
        end
    end

    assign drv.fifo_rst_n    = frst_q;
    assign drv.wr_en         = wr_q;
    assign drv.rd_en         = rd_q;
    assign drv.data_in       = data_q;
    assign drv.sample_strobe = strobe_q;
    assign drv.test_done     = done_q;
    assign drv.txn_count     = txn_q;

    wire unused_inj = ^INJ_IDX;
endmodule

// File: tb/tb_fifo_stim_driver.sv
// Self-checking bench for fifo_stim_driver against a per-run expected trace built from the phase rules.
module tb_fifo_stim_driver;
    localparam int          DW      = 16;
    localparam int          DEPTH   = 8;
    localparam int          NUM_TXN = 20;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          WR_T    = 179;
    localparam int          RD_T    = 77;
    localparam int          PH      = DEPTH + 2;
    localparam int          NSTIM   = 2 * PH + NUM_TXN;
    localparam int          NCYC    = 2 + NSTIM + 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    fifo_stim_driver_if #(.DATA_WIDTH(DW)) drv ();

    fifo_stim_driver #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .NUM_TXN   (NUM_TXN),
        .SEED      (SEED),
        .WR_THRESH (WR_T),
        .RD_THRESH (RD_T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .drv  (drv)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_lfsr;
    logic        e_frst [NCYC];
    logic        e_wr   [NCYC];
    logic        e_rd   [NCYC];
    logic        e_stb  [NCYC];
    logic        e_done [NCYC];
    logic [31:0] e_txn  [NCYC];
    logic [15:0] e_data [NCYC];
    bit          e_dchk [NCYC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Expected trace for one run: 2 RST cycles, NSTIM stimulus cycles, 3 DONE cycles.
    task automatic build_expect();
        int r;
        for (int i = 0; i < 2; i++) begin
            e_frst[i] = 0; e_wr[i] = 0; e_rd[i] = 0; e_stb[i] = 0;
            e_done[i] = 0; e_txn[i] = 0; e_data[i] = '0; e_dchk[i] = 0;
        end
        for (int k = 0; k < NSTIM; k++) begin
            int i = k + 2;
            e_data[i] = model_lfsr; e_dchk[i] = 1; e_txn[i] = k + 1;
            e_frst[i] = 1; e_done[i] = 0; e_stb[i] = (k > 0);
            if (k < PH) begin
                e_wr[i] = 1; e_rd[i] = 0;
            end else if (k < 2 * PH) begin
                e_wr[i] = 0; e_rd[i] = 1;
            end else begin
                r = k - 2 * PH;
                e_wr[i] = (int'(model_lfsr[7:0])  < WR_T);
                e_rd[i] = (int'(model_lfsr[15:8]) < RD_T);
`ifdef FIFO_DRV_RST_INJECT_EN
                if (r == NUM_TXN / 2) begin
                    e_frst[i] = 0; e_wr[i] = 0; e_rd[i] = 0;
                end
`endif
            end
            model_lfsr = galois(model_lfsr);
        end
        for (int j = 0; j < 3; j++) begin
            int i = NSTIM + 2 + j;
            e_frst[i] = 1; e_wr[i] = 0; e_rd[i] = 0;
            e_stb[i] = (j < 2); e_done[i] = (j > 0);
            e_txn[i] = NSTIM; e_data[i] = e_data[NSTIM + 1]; e_dchk[i] = 1;
        end
    endtask

    task automatic run_check(input int ncyc, input int st_a, input int st_b,
                             input bit first, output int strobes);
        strobes = 0;
        for (int i = 0; i < ncyc; i++) begin
            check($sformatf("c%0d fifo_rst_n", i), drv.fifo_rst_n, e_frst[i]);
            check($sformatf("c%0d wr_en", i), drv.wr_en, e_wr[i]);
            check($sformatf("c%0d rd_en", i), drv.rd_en, e_rd[i]);
            check($sformatf("c%0d strobe", i), drv.sample_strobe, e_stb[i]);
            check($sformatf("c%0d test_done", i), drv.test_done, e_done[i]);
            check($sformatf("c%0d txn_count", i), drv.txn_count, e_txn[i]);
            if (e_dchk[i]) check($sformatf("c%0d data_in", i), drv.data_in, e_data[i]);
            if (first && i == 2) check("first fill data", drv.data_in, 32'hACE1);
            if (first && i == 3) check("second fill data", drv.data_in, 32'hE270);
            if (drv.sample_strobe === 1'b1) strobes++;
            start = (i == st_a) || (i == st_b);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic frst, input logic done,
                                 input logic [31:0] txn);
        check({tag, " fifo_rst_n"}, drv.fifo_rst_n, frst);
        check({tag, " wr_en"}, drv.wr_en, 1'b0);
        check({tag, " rd_en"}, drv.rd_en, 1'b0);
        check({tag, " strobe"}, drv.sample_strobe, 1'b0);
        check({tag, " test_done"}, drv.test_done, done);
        check({tag, " txn_count"}, drv.txn_count, txn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        model_lfsr = SEED;
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 32'd0);
        check("reset data_in", drv.data_in, 32'd0);

        rst_n = 1'b1;
        repeat (2 + $urandom_range(0, 3)) begin
            @(negedge clk);
            check_outputs("idle", 1'b1, 1'b0, 32'd0);
        end

        // Run 1: plain full run
        pulse_start();
        build_expect();
        run_check(NCYC, -1, -1, 1'b1, s);
        check("run1 strobes", s, NSTIM + 1);
        repeat (1 + $urandom_range(0, 4)) begin
            check_outputs("done hold", 1'b1, 1'b1, NSTIM);
            @(negedge clk);
        end

        // Run 2: restart from DONE, ignored starts in FILL and RANDOM
        pulse_start();
        check("restart test_done", drv.test_done, 1'b0);
        build_expect();
        run_check(NCYC, $urandom_range(2, 11), $urandom_range(22, 40), 1'b0, s);
        check("run2 strobes", s, NSTIM + 1);

        // Run 3: reset in the middle of DRAIN
        repeat (2) @(negedge clk);
        pulse_start();
        build_expect();
        n = $urandom_range(13, 21);
        run_check(n, -1, -1, 1'b0, s);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("mid-drain reset", 1'b0, 1'b0, 32'd0);
        check("mid-drain reset data_in", drv.data_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = SEED;
        repeat (3 + $urandom_range(0, 5)) begin
            @(negedge clk);
            check_outputs("post-reset idle", 1'b1, 1'b0, 32'd0);
        end

        // Run 4: after reset the LFSR restarts from the seed
        pulse_start();
        build_expect();
        run_check(NCYC, -1, -1, 1'b1, s);
        check("run4 strobes", s, NSTIM + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
